// File: rtl/ca_pkg.sv
// ca_pkg: shared definitions for the cellular-automaton row.
//   ca_state_t          sequencer FSM state encoding
//   CA_RULE_W           width of a rule number
//   CA_WIDTH_DEFAULT    default cell count, shared with the cell array
//   CA_GEN_MAX_DEFAULT  default generations per run, shared with the display reader
package ca_pkg;

    localparam int CA_RULE_W          = 8;
    localparam int CA_WIDTH_DEFAULT   = 32;
    localparam int CA_GEN_MAX_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_STEP    = 3'd4,
        ST_DONE    = 3'd5
    } ca_state_t;

endpackage

// File: rtl/ca_prescaler.sv
// ca_prescaler: loadable down-counter with a zero flag.
//   clk, reset   rising-edge clock, synchronous active-low reset
//   load         load load_value this cycle (takes priority over dec)
//   load_value   value to load
//   dec          decrement by one; holds at zero
//   zero         high while the count is zero
module ca_prescaler #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ca_sequencer.sv
// ca_sequencer: control and capture engine for the cellular-automaton row.
// Latches rule and seed on start, loads the cell array, then paces
// generations with a prescaler and writes each generation's row into a
// history buffer.
//
// Optional feature: define CA_STILL_DETECT_EN to end a run early when a
// captured row equals the previously captured row.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   start           level start, sampled only in IDLE and DONE
//   rule_sw, seed   rule number and initial row, latched on start
//   row_state       current state of all cells
//   rule            latched rule, broadcast to the cells
//   initial_state   latched seed, bit i to cell i
//   load_or_run     1 = cells load initial_state, 0 = cells step
//   cell_en         cell array update enable
//   hist_we         history write strobe
//   hist_addr       history row address (generation index)
//   hist_data       row captured this cycle
//   busy, done      run in progress / run finished
//   state_dbg       current FSM state
//
// Handshake: there is none beyond start; every output is either a register
// or a decode of the state register, except hist_data, which passes
// row_state through only while in CAPTURE.
module ca_sequencer
    import ca_pkg::*;
#(
    parameter int WIDTH    = CA_WIDTH_DEFAULT,
    parameter int GEN_MAX  = CA_GEN_MAX_DEFAULT,
    parameter int PRESCALE = 50_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CA_RULE_W-1:0]       rule_sw,
    input  logic [WIDTH-1:0]           seed,
    input  logic [WIDTH-1:0]           row_state,
    output logic [CA_RULE_W-1:0]       rule,
    output logic [WIDTH-1:0]           initial_state,
    output logic                       load_or_run,
    output logic                       cell_en,
    output logic                       hist_we,
    output logic [$clog2(GEN_MAX)-1:0] hist_addr,
    output logic [WIDTH-1:0]           hist_data,
    output logic                       busy,
    output logic                       done,
    output ca_state_t                  state_dbg
);

    localparam int AW    = $clog2(GEN_MAX);
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [AW-1:0]    GEN_LAST   = AW'(GEN_MAX - 1);
    localparam logic [CNT_W-1:0] WAIT_COUNT = CNT_W'(PRESCALE - 1);

    ca_state_t     state_q, state_d;
    logic [AW-1:0] gen;
    logic          wait_zero;
    logic          still_hit;
    logic          accept_start;

    assign accept_start = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;

    // Loaded on every CAPTURE; only matters when the next state is WAIT.
    ca_prescaler #(.W(CNT_W)) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .load       (state_q == ST_CAPTURE),
        .load_value (WAIT_COUNT),
        .dec        (state_q == ST_WAIT),
        .zero       (wait_zero)
    );

`ifdef CA_STILL_DETECT_EN
    logic [WIDTH-1:0] prev_row;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_row <= '0;
        end else if (state_q == ST_CAPTURE) begin
            prev_row <= row_state;
        end
    end

    // The seed capture (gen 0) has no predecessor to compare against.
    assign still_hit = (gen != '0) && (row_state == prev_row);
`else
    assign still_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
            ST_LOAD:          state_d = ST_CAPTURE;
            ST_CAPTURE:       state_d = ((gen == GEN_LAST) || still_hit) ? ST_DONE : ST_WAIT;
            ST_WAIT:          if (wait_zero) state_d = ST_STEP;
            ST_STEP:          state_d = ST_CAPTURE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Latched run parameters and generation index
    always_ff @(posedge clk) begin
        if (!reset) begin
            rule          <= '0;
            initial_state <= '0;
            gen           <= '0;
        end else if (accept_start) begin
            rule          <= rule_sw;
            initial_state <= seed;
            gen           <= '0;
        end else if (state_q == ST_STEP) begin
            gen <= gen + 1'b1;
        end
    end

    // Output decode
    always_comb begin
        load_or_run = 1'b0;
        cell_en     = 1'b0;
        hist_we     = 1'b0;
        hist_data   = '0;
        case (state_q)
            ST_LOAD: begin
                cell_en     = 1'b1;
                load_or_run = 1'b1;
            end
            ST_STEP: begin
                cell_en = 1'b1;
            end
            ST_CAPTURE: begin
                hist_we   = 1'b1;
                hist_data = row_state;
            end
            default: ;
        endcase
    end

    assign hist_addr = gen;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ca_sequencer.sv
// Bench for ca_sequencer: two instances (PRESCALE=2 and PRESCALE=1,
// WIDTH=8, GEN_MAX=4), each driving a behavioural model of the cell array.
module tb_ca_sequencer;
    import ca_pkg::*;

    localparam int W  = 8;
    localparam int GM = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 0 (PRESCALE=2) ----------------
    logic         start0 = 1'b0;
    logic [7:0]   rule_sw0 = 8'd0;
    logic [W-1:0] seed0 = '0;
    logic [W-1:0] row0 = '0;
    logic [7:0]   rule0;
    logic [W-1:0] init0;
    logic         lor0, ce0, we0, busy0, done0;
    logic [1:0]   addr0;
    logic [W-1:0] data0;
    ca_state_t    st0;

    ca_sequencer #(.WIDTH(W), .GEN_MAX(GM), .PRESCALE(2)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .rule_sw(rule_sw0), .seed(seed0),
        .row_state(row0), .rule(rule0), .initial_state(init0), .load_or_run(lor0),
        .cell_en(ce0), .hist_we(we0), .hist_addr(addr0), .hist_data(data0),
        .busy(busy0), .done(done0), .state_dbg(st0)
    );

    // ---------------- DUT 1 (PRESCALE=1) ----------------
    logic         start1 = 1'b0;
    logic [7:0]   rule_sw1 = 8'd90;
    logic [W-1:0] seed1 = 8'h10;
    logic [W-1:0] row1 = '0;
    logic [7:0]   rule1;
    logic [W-1:0] init1;
    logic         lor1, ce1, we1, busy1, done1;
    logic [1:0]   addr1;
    logic [W-1:0] data1;
    ca_state_t    st1;

    ca_sequencer #(.WIDTH(W), .GEN_MAX(GM), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .rule_sw(rule_sw1), .seed(seed1),
        .row_state(row1), .rule(rule1), .initial_state(init1), .load_or_run(lor1),
        .cell_en(ce1), .hist_we(we1), .hist_addr(addr1), .hist_data(data1),
        .busy(busy1), .done(done1), .state_dbg(st1)
    );

    // ---------------- cell array model (wrap-around neighbourhood) ----------------
    function automatic logic [W-1:0] next_row(input logic [W-1:0] r, input logic [7:0] rl);
        logic [W-1:0] n;
        logic [2:0]   idx;
        for (int i = 0; i < W; i++) begin
            idx  = {r[(i + 1) % W], r[i], r[(i + W - 1) % W]};
            n[i] = rl[idx];
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (ce0) row0 <= lor0 ? init0 : next_row(row0, rule0);
        if (ce1) row1 <= lor1 ? init1 : next_row(row1, rule1);
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Capture monitor, sampled 1 time unit after each rising edge.
    int cyc = 0;
    logic [W-1:0] cap0_data[$];
    logic [1:0]   cap0_addr[$];
    logic [W-1:0] cap1_data[$];
    logic [1:0]   cap1_addr[$];
    int           cap1_cyc[$];
    int           load1_cyc = -1;
    int           done1_cyc = -1;
    int           steps1 = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (we0) begin
            cap0_data.push_back(data0);
            cap0_addr.push_back(addr0);
        end
        if (we1) begin
            cap1_data.push_back(data1);
            cap1_addr.push_back(addr1);
            cap1_cyc.push_back(cyc);
        end
        if (ce1 && lor1) load1_cyc = cyc;
        if (ce1 && !lor1) steps1++;
        if (done1 && (done1_cyc < 0)) done1_cyc = cyc;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       ce, lor, we, busy, done;
        logic [1:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic ce, input logic lor, input logic we,
                                input logic bsy, input logic dn,
                                input logic [1:0] a, input logic [7:0] d);
        vec_t v;
        v.ce = ce; v.lor = lor; v.we = we; v.busy = bsy; v.done = dn;
        v.addr = a; v.data = d;
        return v;
    endfunction

    task automatic fill_vecs();
        logic [7:0] rows[4];
        rows[0] = 8'h10; rows[1] = 8'h28; rows[2] = 8'h44; rows[3] = 8'hAA;
        vecs[0] = mk(1, 1, 0, 1, 0, 2'd0, 8'h00);          // LOAD
        for (int g = 0; g < 4; g++) begin
            vecs[1 + 4*g] = mk(0, 0, 1, 1, 0, 2'(g), rows[g]); // CAPTURE
            if (g < 3) begin
                vecs[2 + 4*g] = mk(0, 0, 0, 1, 0, 2'(g), 8'h00); // WAIT
                vecs[3 + 4*g] = mk(0, 0, 0, 1, 0, 2'(g), 8'h00); // WAIT
                vecs[4 + 4*g] = mk(1, 0, 0, 1, 0, 2'(g), 8'h00); // STEP
            end
        end
        vecs[14] = mk(0, 0, 0, 0, 1, 2'd3, 8'h00);         // DONE
    endtask

    // Start DUT 0 with rule 90 / seed 0x10 and walk the trace table.
    // mutate: change rule_sw/seed in WAIT; hold: keep start high mid-run.
    task automatic run_trace(input string tag, input bit mutate, input bit hold);
        rule_sw0 = 8'd90;
        seed0    = 8'h10;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = hold;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("%s[%0d].cell_en", tag, i), 32'(ce0), 32'(vecs[i].ce));
            chk($sformatf("%s[%0d].load_or_run", tag, i), 32'(lor0), 32'(vecs[i].lor));
            chk($sformatf("%s[%0d].hist_we", tag, i), 32'(we0), 32'(vecs[i].we));
            chk($sformatf("%s[%0d].busy", tag, i), 32'(busy0), 32'(vecs[i].busy));
            chk($sformatf("%s[%0d].done", tag, i), 32'(done0), 32'(vecs[i].done));
            chk($sformatf("%s[%0d].rule", tag, i), 32'(rule0), 32'd90);
            chk($sformatf("%s[%0d].initial_state", tag, i), 32'(init0), 32'h10);
            if (vecs[i].we || vecs[i].done)
                chk($sformatf("%s[%0d].hist_addr", tag, i), 32'(addr0), 32'(vecs[i].addr));
            if (vecs[i].we)
                chk($sformatf("%s[%0d].hist_data", tag, i), 32'(data0), 32'(vecs[i].data));
            if (mutate && i == 2) begin
                rule_sw0 = 8'd30;
                seed0    = 8'hFF;
            end
            if (hold && i == 11) start0 = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rule"}, 32'(rule0), 32'd0);
        chk({tag, ".initial_state"}, 32'(init0), 32'd0);
        chk({tag, ".load_or_run"}, 32'(lor0), 32'd0);
        chk({tag, ".cell_en"}, 32'(ce0), 32'd0);
        chk({tag, ".hist_we"}, 32'(we0), 32'd0);
        chk({tag, ".hist_addr"}, 32'(addr0), 32'd0);
        chk({tag, ".hist_data"}, 32'(data0), 32'd0);
        chk({tag, ".busy"}, 32'(busy0), 32'd0);
        chk({tag, ".done"}, 32'(done0), 32'd0);
        chk({tag, ".state"}, 32'(st0), 32'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] exp_q[$];
        int           we_count;
        int           n_exp;
        bit           got;

        fill_vecs();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset.dut1_busy", 32'(busy1), 32'd0);
        chk("reset.dut1_done", 32'(done1), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ignores_nothing.state", 32'(st0), 32'(ST_IDLE));

        // Basic run from IDLE
        run_trace("run1", 1'b0, 1'b0);
        // Restart from DONE, with input changes and start held high mid-run
        run_trace("run2", 1'b1, 1'b1);

        // Reset mid-WAIT
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midwait.state", 32'(st0), 32'(ST_WAIT));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("midwait_reset");
        @(negedge clk);
        reset = 1'b1;
        we_count = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (we0 || busy0) we_count++;
        end
        chk("post_reset.activity", 32'(we_count), 32'd0);
        chk("post_reset.state", 32'(st0), 32'(ST_IDLE));

        // PRESCALE=1 boundary on DUT 1
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done1) got = 1'b1;
        end
        chk("p1.done_timeout", 32'(got), 32'd1);
        exp_q = '{8'h10, 8'h28, 8'h44, 8'hAA};
        chk("p1.capture_count", 32'(cap1_data.size()), 32'd4);
        chk("p1.step_count", 32'(steps1), 32'd3);
        if (cap1_data.size() == 4) begin
            chk("p1.first_capture_after_load", 32'(cap1_cyc[0] - load1_cyc), 32'd1);
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("p1.cap%0d.addr", g), 32'(cap1_addr[g]), 32'(g));
                chk($sformatf("p1.cap%0d.data", g), 32'(cap1_data[g]), 32'(exp_q[g]));
                if (g > 0)
                    chk($sformatf("p1.cap%0d.period", g), 32'(cap1_cyc[g] - cap1_cyc[g-1]), 32'd3);
            end
            chk("p1.done_after_last", 32'(done1_cyc - cap1_cyc[3]), 32'd1);
        end

        // Identity rule: still-row behaviour on DUT 0
        cap0_data.delete();
        cap0_addr.delete();
        rule_sw0 = 8'd204;
        seed0    = 8'h3C;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done0) got = 1'b1;
        end
        chk("still.done_timeout", 32'(got), 32'd1);
`ifdef CA_STILL_DETECT_EN
        n_exp = 2;
`else
        n_exp = 4;
`endif
        chk("still.capture_count", 32'(cap0_data.size()), 32'(n_exp));
        chk("still.done_addr", 32'(addr0), 32'(n_exp - 1));
        for (int g = 0; g < n_exp && g < cap0_data.size(); g++) begin
            chk($sformatf("still.cap%0d.addr", g), 32'(cap0_addr[g]), 32'(g));
            chk($sformatf("still.cap%0d.data", g), 32'(cap0_data[g]), 32'h3C);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

endmodule
